// File: rtl/match_scoreboard_if.sv
// rtl/match_scoreboard_if.sv - scoreboard input events and registered match outputs
// master drives the scored/new_game levels, slave is the scoreboard itself.
interface match_scoreboard_if #(
   parameter int SCORE_W = 3
);
   logic               new_game;
   logic               player_scored;
   logic               cpu_scored;
   logic [SCORE_W-1:0] player_score;
   logic [SCORE_W-1:0] cpu_score;
   logic               player_win;
   logic               cpu_win;
   logic               game_over;
   logic               serve_player;
   logic               point_pulse;

   modport master (
      output new_game, player_scored, cpu_scored,
      input  player_score, cpu_score, player_win, cpu_win, game_over,
             serve_player, point_pulse
   );

   modport slave (
      input  new_game, player_scored, cpu_scored,
      output player_score, cpu_score, player_win, cpu_win, game_over,
             serve_player, point_pulse
   );
endinterface

// File: rtl/match_scoreboard.sv
// rtl/match_scoreboard.sv - edge-detected point scoring, win/over FSM and serve rotation
// Optional win-by-two with deuce reload: define MATCH_SCOREBOARD_WIN_BY_TWO_EN.
module match_scoreboard #(
   parameter int SCORE_W   = 3,
   parameter int WIN_SCORE = 4,
   parameter int SERVE_PTS = 2
) (
   input logic               clk,
   input logic               rst,
   match_scoreboard_if.slave sb
);

   if (WIN_SCORE < 2 || WIN_SCORE > (2**SCORE_W) - 1) begin : g_bad_win_score
      $error("match_scoreboard: WIN_SCORE must be in 2 .. 2**SCORE_W-1");
   end
   if (SERVE_PTS < 1) begin : g_bad_serve_pts
      $error("match_scoreboard: SERVE_PTS must be >= 1");
   end

   localparam int CNT_W = (SERVE_PTS > 1) ? $clog2(SERVE_PTS) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_PTS - 1);
   localparam logic [SCORE_W:0]   WIN_X    = (SCORE_W + 1)'(WIN_SCORE);
   localparam logic [SCORE_W:0]   ONE_X    = (SCORE_W + 1)'(1);
`ifdef MATCH_SCOREBOARD_WIN_BY_TWO_EN
   localparam logic [SCORE_W:0]   TWO_X    = (SCORE_W + 1)'(2);
   localparam logic [SCORE_W:0]   DEUCE_X  = (SCORE_W + 1)'(WIN_SCORE - 1);
`endif

   localparam logic [0:0] S_PLAY = 1'b0;
   localparam logic [0:0] S_OVER = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [SCORE_W-1:0] p_score_q, p_score_d, c_score_q, c_score_d;
   logic               p_win_q, p_win_d, c_win_q, c_win_d;
   logic               serve_q, serve_d;
   logic               pulse_q, pulse_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               p_prev_q, c_prev_q;

   logic               p_ev, c_ev;
   logic [SCORE_W-1:0] sc, ot, sc_n, ot_n;
   logic [SCORE_W:0]   sc_inc;
   logic               win;

   assign p_ev = sb.player_scored & ~p_prev_q;
   assign c_ev = sb.cpu_scored & ~c_prev_q;

   // The scoring side is muxed into sc/ot so one rule set serves both players.
   always_comb begin
      state_d   = state_q;
      p_score_d = p_score_q;
      c_score_d = c_score_q;
      p_win_d   = p_win_q;
      c_win_d   = c_win_q;
      serve_d   = serve_q;
      cnt_d     = cnt_q;
      pulse_d   = 1'b0;

      sc     = p_ev ? p_score_q : c_score_q;
      ot     = p_ev ? c_score_q : p_score_q;
      sc_inc = {1'b0, sc} + ONE_X;
      sc_n   = sc_inc[SCORE_W-1:0];
      ot_n   = ot;
      win    = 1'b0;
`ifdef MATCH_SCOREBOARD_WIN_BY_TWO_EN
      if (sc_inc >= WIN_X && sc_inc >= ({1'b0, ot} + TWO_X)) begin
         win  = 1'b1;
         sc_n = WIN_X[SCORE_W-1:0];
      end else if (sc_inc == WIN_X && {1'b0, ot} == WIN_X) begin
         sc_n = DEUCE_X[SCORE_W-1:0];
         ot_n = DEUCE_X[SCORE_W-1:0];
      end
`else
      win = (sc_inc == WIN_X);
`endif

      if (state_q == S_PLAY && (p_ev ^ c_ev)) begin
         pulse_d = 1'b1;
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            serve_d = ~serve_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         if (p_ev) begin
            p_score_d = sc_n;
            c_score_d = ot_n;
            p_win_d   = win;
         end else begin
            c_score_d = sc_n;
            p_score_d = ot_n;
            c_win_d   = win;
         end
         if (win) state_d = S_OVER;
      end
   end

   // Edge flops reset to 1 so a level already high at reset release never scores.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_PLAY;
         p_score_q <= '0;
         c_score_q <= '0;
         p_win_q   <= 1'b0;
         c_win_q   <= 1'b0;
         serve_q   <= 1'b1;
         pulse_q   <= 1'b0;
         cnt_q     <= '0;
         p_prev_q  <= 1'b1;
         c_prev_q  <= 1'b1;
      end else begin
         p_prev_q <= sb.player_scored;
         c_prev_q <= sb.cpu_scored;
         if (sb.new_game) begin
            state_q   <= S_PLAY;
            p_score_q <= '0;
            c_score_q <= '0;
            p_win_q   <= 1'b0;
            c_win_q   <= 1'b0;
            serve_q   <= 1'b1;
            pulse_q   <= 1'b0;
            cnt_q     <= '0;
         end else begin
            state_q   <= state_d;
            p_score_q <= p_score_d;
            c_score_q <= c_score_d;
            p_win_q   <= p_win_d;
            c_win_q   <= c_win_d;
            serve_q   <= serve_d;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
         end
      end
   end

   assign sb.player_score = p_score_q;
   assign sb.cpu_score    = c_score_q;
   assign sb.player_win   = p_win_q;
   assign sb.cpu_win      = c_win_q;
   assign sb.game_over    = state_q;
   assign sb.serve_player = serve_q;
   assign sb.point_pulse  = pulse_q;

endmodule

// File: tb/tb_match_scoreboard.sv
// tb/tb_match_scoreboard.sv - vector table, corner sequences and random run against a match model
module tb_match_scoreboard;
   localparam int SCORE_W   = 3;
   localparam int WIN_SCORE = 4;
   localparam int SERVE_PTS = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   match_scoreboard_if #(.SCORE_W(SCORE_W)) sbi ();

   match_scoreboard #(
      .SCORE_W  (SCORE_W),
      .WIN_SCORE(WIN_SCORE),
      .SERVE_PTS(SERVE_PTS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sb (sbi.slave)
   );

   typedef struct {
      bit ng, ps, cs;
      int p, c, pw, cw, ov, sv, pu;
   } vec_t;
   vec_t vecs[$];

   int checks = 0;
   int errors = 0;

   // Match model: scores as plain integers, serve tracked by points mod SERVE_PTS.
   int m_p, m_c, m_pw, m_cw, m_ov, m_sv, m_pu, m_served;
   bit m_pprev, m_cprev;

   function automatic void model_clear();
      m_p = 0; m_c = 0; m_pw = 0; m_cw = 0; m_ov = 0; m_sv = 1; m_pu = 0; m_served = 0;
   endfunction

   function automatic void model_reset();
      model_clear();
      m_pprev = 1'b1;
      m_cprev = 1'b1;
   endfunction

   function automatic void award(inout int mine, inout int theirs, inout int flag);
      mine = mine + 1;
`ifdef MATCH_SCOREBOARD_WIN_BY_TWO_EN
      if (mine >= WIN_SCORE && mine - theirs >= 2) begin
         mine = WIN_SCORE; flag = 1; m_ov = 1;
      end else if (mine == WIN_SCORE && theirs == WIN_SCORE) begin
         mine = WIN_SCORE - 1; theirs = WIN_SCORE - 1;
      end
`else
      if (mine == WIN_SCORE) begin
         flag = 1; m_ov = 1;
      end
`endif
   endfunction

   function automatic void model_clock(bit ng, bit ps, bit cs);
      bit pe, ce;
      pe = ps && !m_pprev;
      ce = cs && !m_cprev;
      m_pprev = ps;
      m_cprev = cs;
      m_pu = 0;
      if (ng) begin
         model_clear();
      end else if (m_ov == 0 && pe != ce) begin
         m_pu = 1;
         m_served = (m_served + 1) % SERVE_PTS;
         if (m_served == 0) m_sv = 1 - m_sv;
         if (pe) award(m_p, m_c, m_pw);
         else    award(m_c, m_p, m_cw);
      end
   endfunction

   task automatic chk(input string tag, input string what, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s %s: got %0d, expected %0d", tag, what, act, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input int p, input int c, input int pw,
                              input int cw, input int ov, input int sv, input int pu);
      chk(tag, "player_score", int'(sbi.player_score), p);
      chk(tag, "cpu_score",    int'(sbi.cpu_score),    c);
      chk(tag, "player_win",   int'(sbi.player_win),   pw);
      chk(tag, "cpu_win",      int'(sbi.cpu_win),      cw);
      chk(tag, "game_over",    int'(sbi.game_over),    ov);
      chk(tag, "serve_player", int'(sbi.serve_player), sv);
      chk(tag, "point_pulse",  int'(sbi.point_pulse),  pu);
   endtask

   task automatic chk_model(input string tag);
      chk_outputs(tag, m_p, m_c, m_pw, m_cw, m_ov, m_sv, m_pu);
   endtask

   task automatic step(input bit ng, input bit ps, input bit cs);
      sbi.new_game      = ng;
      sbi.player_scored = ps;
      sbi.cpu_scored    = cs;
      @(posedge clk);
      model_clock(ng, ps, cs);
      #1;
   endtask

   task automatic pulse_pt(input bit player);
      step(1'b0, player, !player);
      step(1'b0, 1'b0, 1'b0);
   endtask

   // Called 1 time unit after a rising edge; reset lands mid-cycle.
   task automatic async_reset(input string tag);
      #3 rst = 1'b1;
      model_reset();
      #1;
      chk_outputs(tag, 0, 0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   function automatic void add(bit ng, bit ps, bit cs, int p, int c, int pw, int cw,
                               int ov, int sv, int pu);
      vec_t v;
      v.ng = ng; v.ps = ps; v.cs = cs;
      v.p = p; v.c = c; v.pw = pw; v.cw = cw; v.ov = ov; v.sv = sv; v.pu = pu;
      vecs.push_back(v);
   endfunction

   initial begin
      //  ng ps cs   p  c pw cw ov sv pu
      add(0, 0, 0,   0, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0,   1, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0,   1, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0,   2, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0,   2, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0,   3, 0, 0, 0, 0, 0, 1);
      add(0, 0, 0,   3, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0,   4, 0, 1, 0, 1, 1, 1);
      add(0, 1, 0,   4, 0, 1, 0, 1, 1, 0);
      add(0, 0, 1,   4, 0, 1, 0, 1, 1, 0);
      add(0, 0, 0,   4, 0, 1, 0, 1, 1, 0);
      add(1, 0, 1,   0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 1,   0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 0,   0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 1,   0, 1, 0, 0, 0, 1, 1);
      for (int i = 0; i < 9; i++) add(0, 0, 1, 0, 1, 0, 0, 0, 1, 0);
      add(0, 0, 0,   0, 1, 0, 0, 0, 1, 0);
      add(0, 1, 1,   0, 1, 0, 0, 0, 1, 0);
      add(0, 0, 0,   0, 1, 0, 0, 0, 1, 0);
      add(0, 0, 1,   0, 2, 0, 0, 0, 0, 1);
      add(0, 0, 0,   0, 2, 0, 0, 0, 0, 0);
      add(0, 1, 0,   1, 2, 0, 0, 0, 0, 1);
      add(0, 0, 0,   1, 2, 0, 0, 0, 0, 0);
      add(0, 1, 0,   2, 2, 0, 0, 0, 1, 1);
      add(0, 0, 0,   2, 2, 0, 0, 0, 1, 0);
      add(0, 1, 0,   3, 2, 0, 0, 0, 1, 1);
      add(0, 0, 0,   3, 2, 0, 0, 0, 1, 0);
      add(0, 1, 0,   4, 2, 1, 0, 1, 0, 1);
      add(0, 0, 0,   4, 2, 1, 0, 1, 0, 0);
      add(0, 0, 1,   4, 2, 1, 0, 1, 0, 0);
      add(1, 0, 0,   0, 0, 0, 0, 0, 1, 0);
      add(0, 0, 0,   0, 0, 0, 0, 0, 1, 0);
      add(0, 1, 0,   1, 0, 0, 0, 0, 1, 1);
      add(0, 0, 0,   1, 0, 0, 0, 0, 1, 0);
      add(0, 0, 1,   1, 1, 0, 0, 0, 0, 1);
      add(0, 0, 0,   1, 1, 0, 0, 0, 0, 0);
      add(0, 1, 0,   2, 1, 0, 0, 0, 0, 1);
      add(0, 0, 0,   2, 1, 0, 0, 0, 0, 0);
      add(0, 0, 1,   2, 2, 0, 0, 0, 1, 1);
      add(0, 0, 0,   2, 2, 0, 0, 0, 1, 0);
      add(0, 1, 0,   3, 2, 0, 0, 0, 1, 1);

      rst = 1'b1;
      sbi.new_game = 1'b0;
      sbi.player_scored = 1'b0;
      sbi.cpu_scored = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_outputs("reset", 0, 0, 0, 0, 0, 1, 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         step(vecs[i].ng, vecs[i].ps, vecs[i].cs);
         chk_outputs($sformatf("vec%0d", i), vecs[i].p, vecs[i].c, vecs[i].pw,
                     vecs[i].cw, vecs[i].ov, vecs[i].sv, vecs[i].pu);
      end

      // Reset arrives while point_pulse is high and player_scored is still held.
      async_reset("async_rst");
      step(1'b0, 1'b1, 1'b0);
      chk_outputs("held_thru_rst", 0, 0, 0, 0, 0, 1, 0);
      step(1'b0, 1'b0, 1'b0);

`ifdef MATCH_SCOREBOARD_WIN_BY_TWO_EN
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         pulse_pt(1'b1);
         pulse_pt(1'b0);
      end
      chk_outputs("deuce_3_3", 3, 3, 0, 0, 0, m_sv, 0);
      step(1'b0, 1'b1, 1'b0);
      chk_outputs("adv_player", 4, 3, 0, 0, 0, m_sv, 1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      chk_outputs("back_to_deuce", 3, 3, 0, 0, 0, m_sv, 1);
      step(1'b0, 1'b0, 1'b0);
      pulse_pt(1'b1);
      chk_outputs("adv_again", 4, 3, 0, 0, 0, m_sv, 0);
      step(1'b0, 1'b1, 1'b0);
      chk_outputs("win_by_two", 4, 3, 1, 0, 1, m_sv, 1);
      step(1'b0, 1'b0, 1'b0);
`endif

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
         chk_model($sformatf("rnd%0d", i));
         if ($urandom_range(0, 149) == 0) async_reset($sformatf("rnd_rst%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/match_scoreboard.md
MATCH_SCOREBOARD -- requirements
Module: match_scoreboard

Interface
REQ-001 Parameter SCORE_W, default 3: width of each score output in bits.
REQ-002 Parameter WIN_SCORE, default 4: points needed to win; elaboration SHALL fail unless 2 <= WIN_SCORE <= 2**SCORE_W-1.
REQ-003 Parameter SERVE_PTS, default 2: accepted points between serve changes; SHALL be >= 1.
REQ-004 clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 new_game  in  1  synchronous level; clears the match.
REQ-007 player_scored  in  1  level from ball logic; only rising edges count.
REQ-008 cpu_scored  in  1  level from ball logic; only rising edges count.
REQ-009 player_score  out  SCORE_W  registered player points.
REQ-010 cpu_score  out  SCORE_W  registered CPU points.
REQ-011 player_win  out  1  registered; high while the player has won.
REQ-012 cpu_win  out  1  registered; high while the CPU has won.
REQ-013 game_over  out  1  registered; high in state OVER.
REQ-014 serve_player  out  1  registered; 1 = player serves, 0 = CPU serves.
REQ-015 point_pulse  out  1  registered one-cycle strobe per accepted point.

Function
REQ-016 Each scored input SHALL have a registered previous-value flop; a point event SHALL be input=1 while prev=0 at a clock edge.
REQ-017 Scores, flags and point_pulse SHALL update on the same edge that detects the event, giving 1-cycle latency from input rise to output change.
REQ-018 A level held high SHALL score once; a new point SHALL need a low sample first.
REQ-019 FSM states: PLAY and OVER; reset and new_game SHALL enter PLAY.
REQ-020 In PLAY, a single event SHALL add 1 to that side's score and pulse point_pulse for exactly one cycle.
REQ-021 Both events in the same cycle SHALL be a let: no score change, no pulse, serve counter unchanged.
REQ-022 Base win rule: when a side's score after increment equals WIN_SCORE, its win flag SHALL set and the FSM SHALL enter OVER on that edge.
REQ-023 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-024 In OVER, events SHALL be ignored (no pulse, no score change), and scores and win flag SHALL hold until new_game or rst.
REQ-025 Exactly one win flag SHALL be high in OVER; both SHALL be low in PLAY.
REQ-026 A modulo-SERVE_PTS counter SHALL count accepted points; when it wraps, serve_player SHALL toggle on that edge.
REQ-027 new_game SHALL take priority over a same-cycle event; edge-detect flops SHALL still sample inputs during new_game.

Reset
REQ-028 rst high SHALL asynchronously force: scores 0, player_win 0, cpu_win 0, game_over 0, point_pulse 0, serve_player 1, serve counter 0, FSM PLAY.
REQ-029 rst high SHALL also load both edge-detect flops with 1, so an input already high at reset release does not score.
REQ-030 new_game SHALL apply the same values as rst, synchronously, except that the edge-detect flops keep sampling the inputs.

Configuration
REQ-031 Macro MATCH_SCOREBOARD_WIN_BY_TWO_EN, when defined, SHALL require a side to hold >= WIN_SCORE points and lead by >= 2 to win.
REQ-032 With the macro defined, a tie at WIN_SCORE SHALL reload both scores to WIN_SCORE-1 on that edge (deuce), keeping values within WIN_SCORE.
REQ-033 With the macro defined, a side at WIN_SCORE that scores again SHALL win with its score held at WIN_SCORE.
REQ-034 With the macro undefined, REQ-022 SHALL apply unchanged and no deuce logic SHALL be generated.

Verification (defaults, macro off unless stated)
REQ-035 Four separate player_scored pulses -> player_score 1,2,3,4; fourth edge sets player_win=1 and game_over=1; cpu_win stays 0.
REQ-036 cpu_scored held high 10 cycles -> cpu_score=1, exactly one point_pulse.
REQ-037 Both inputs rise in the same cycle -> scores unchanged, no pulse, serve_player unchanged.
REQ-038 Player 4:2 in OVER, then cpu pulse -> no change; then new_game for 1 cycle -> all outputs at reset values and serve_player=1.
REQ-039 Macro on, scores 3:3, player point -> 4:3; cpu point -> 3:3 deuce; player, player -> 4:3 then win with player_score=4.
REQ-040 Four accepted points -> serve_player sequence 1,1,0,0,1; rst asserted mid-cycle -> outputs clear immediately, without waiting for clk.
